// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch and load/store.
// One outstanding transaction at a time, with a watchdog that aborts transactions that are never acknowledged.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_size,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [1:0]    m_size,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} master_t;

    state_t        state, state_nx;
    master_t       sel, last_grant;
    logic          grant_f, grant_d, timeout_hit;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Arbitration and next-state: on a tie the requester that did not win last time is granted
    always_comb begin
        state_nx    = state;
        grant_f     = 1'b0;
        grant_d     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (f_req && d_req) begin
                    if (last_grant == DATA) grant_f = 1'b1;
                    else                    grant_d = 1'b1;
                end else if (f_req) begin
                    grant_f = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_f || grant_d) state_nx = BUSY;
            end
            BUSY: begin
                if (m_ack) begin
                    state_nx = RESP;
                end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nx    = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= FETCH;
            last_grant <= DATA;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_size     <= 2'b00;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else if (grant_f) begin
            sel        <= FETCH;
            last_grant <= FETCH;
            m_we       <= 1'b0;
            m_addr     <= f_addr;
            m_wdata    <= '0;
            m_size     <= 2'b10;
            cnt        <= '0;
        end else if (grant_d) begin
            sel        <= DATA;
            last_grant <= DATA;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            m_size     <= d_size;
            cnt        <= '0;
        end else if (state == BUSY) begin
            // An ack in the watchdog's final cycle still completes normally
            if (m_ack) begin
                rdata_q <= m_we ? '0 : m_rdata;
                err_q   <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                if (timeout_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign m_req   = (state == BUSY);
    assign busy    = (state != IDLE);
    assign f_done  = (state == RESP) && (sel == FETCH);
    assign d_done  = (state == RESP) && (sel == DATA);
    assign f_rdata = f_done ? rdata_q : '0;
    assign d_rdata = d_done ? rdata_q : '0;
    assign err     = (state == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and response values.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req, d_we, m_ack;
    logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_size;
    logic        f_done, d_done, err, m_req, m_we, busy;
    logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_size;

    int n_vec = 0;
    int n_err = 0;
    int last_g = 1;       // model: 0 = fetch, 1 = data granted last
    int last_winner = -1;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        last_g = 1;
    endtask

    // One complete transaction from the IDLE cycle onward, checked against the model.
    // ack_at: BUSY cycle index carrying m_ack (<0 or >=TO means never acknowledged).
    task automatic run_txn(input int ack_at, input logic [31:0] ack_data,
                           input int drop_at, input bit renew);
        int          winner, n_busy;
        bit          acked;
        logic [97:0] exp_fields;
        logic [31:0] exp_rdata;
        if (f_req && d_req) winner = (last_g == 1) ? 0 : 1;
        else if (f_req)     winner = 0;
        else                winner = 1;
        exp_fields = (winner == 0) ? {1'b0, f_addr, 32'h0, 2'b10}
                                   : {d_we, d_addr, d_wdata, d_size};
        acked  = (ack_at >= 0) && (ack_at < TO);
        n_busy = acked ? ack_at + 1 : TO;
        exp_rdata = (!acked || (winner == 1 && d_we)) ? 32'h0 : ack_data;
        tick();
        for (int i = 0; i < n_busy; i++) begin
            n_vec++;
            if ({m_req, busy, f_done, d_done} !== 4'b1100) begin
                n_err++;
                $display("FAIL busy_ctl[%0d]: got req/busy/fd/dd=%b expected 1100", i, {m_req, busy, f_done, d_done});
            end
            n_vec++;
            if ({m_we, m_addr, m_wdata, m_size} !== exp_fields) begin
                n_err++;
                $display("FAIL mem_fields[%0d]: got %h expected %h", i, {m_we, m_addr, m_wdata, m_size}, exp_fields);
            end
            if (i == drop_at) begin
                if (winner == 0) f_req = 1'b0;
                else             d_req = 1'b0;
            end
            if (i == ack_at) begin
                m_ack = 1'b1;
                m_rdata = ack_data;
            end
            tick();
            m_ack = 1'b0;
            m_rdata = $urandom;
        end
        n_vec++;
        if ({m_req, busy, f_done, d_done} !== {2'b01, winner == 0, winner == 1}) begin
            n_err++;
            $display("FAIL resp_ctl: got req/busy/fd/dd=%b expected %b", {m_req, busy, f_done, d_done},
                     {2'b01, winner == 0, winner == 1});
        end
        n_vec++;
        if (((winner == 0) ? f_rdata : d_rdata) !== exp_rdata || err !== !acked) begin
            n_err++;
            $display("FAIL resp_data: got rdata=%h err=%b expected rdata=%h err=%b",
                     (winner == 0) ? f_rdata : d_rdata, err, exp_rdata, !acked);
        end
        last_g = winner;
        last_winner = winner;
        tick();
        n_vec++;
        if ({m_req, busy, f_done, d_done, err} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_after_resp: got req/busy/fd/dd/err=%b expected 00000", {m_req, busy, f_done, d_done, err});
        end
        if (winner == 0) begin
            if (renew) f_addr = $urandom;
            else       f_req = 1'b0;
        end else begin
            if (renew) begin
                d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_size = 2'($urandom_range(0, 2));
            end else begin
                d_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0; m_rdata = '0;
        #1;
        n_vec++;
        if ({f_done, d_done, err, m_req, m_we, busy, m_size} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b expected 00000000", {f_done, d_done, err, m_req, m_we, busy, m_size});
        end
        n_vec++;
        if ({f_rdata, d_rdata, m_addr, m_wdata} !== 128'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", {f_rdata, d_rdata, m_addr, m_wdata});
        end
        tick();
        tick();
        rst_n = 1'b1;
        last_g = 1;
    endtask

    task automatic test_single_fetch();
        f_req = 1'b1; f_addr = 32'h0000_0004;
        run_txn(0, 32'h00A0_0093, -1, 1'b0);
    endtask

    task automatic test_round_robin();
        int exp_order [4];
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        do_reset();
        f_req = 1'b1; f_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0000; d_wdata = '0; d_size = 2'b10;
        for (int t = 0; t < 4; t++) begin
            run_txn(2, $urandom, -1, 1'b1);
            n_vec++;
            if (last_winner !== exp_order[t]) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %0d expected %0d", t, last_winner, exp_order[t]);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1100_0000; d_wdata = 32'hDEAD_BEEF; d_size = 2'b00;
        run_txn(2, 32'h1234_5678, -1, 1'b0);
    endtask

    task automatic test_timeout();
        f_req = 1'b1; f_addr = 32'h0000_0040;
        run_txn(-1, 32'h0, -1, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080; d_size = 2'b10;
        run_txn(0, 32'hCAFE_0001, -1, 1'b0);
        f_req = 1'b1; f_addr = 32'h0000_0044;
        run_txn(TO - 1, 32'h0BAD_F00D, -1, 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        f_req = 1'b1; f_addr = 32'h0000_0100;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m_req, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset: got req/busy=%b expected 00", {m_req, busy});
        end
        f_req = 1'b0;
        tick();
        rst_n = 1'b1;
        last_g = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({f_done, d_done, busy} !== 3'b000) begin
                n_err++;
                $display("FAIL no_done_after_reset[%0d]: got fd/dd/busy=%b expected 000", i, {f_done, d_done, busy});
            end
        end
        f_req = 1'b1; f_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_size = 2'b01;
        run_txn(1, $urandom, -1, 1'b0);
        n_vec++;
        if (last_winner !== 0) begin
            n_err++;
            $display("FAIL post_reset_tie: got %0d expected 0", last_winner);
        end
        run_txn(1, $urandom, -1, 1'b0);
    endtask

    task automatic test_drop_req();
        f_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; d_size = 2'b10;
        run_txn(3, 32'h5555_AAAA, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({m_req, busy, d_done} !== 3'b000) begin
                n_err++;
                $display("FAIL no_regrant[%0d]: got req/busy/dd=%b expected 000", i, {m_req, busy, d_done});
            end
        end
    endtask

    task automatic test_random();
        int a;
        for (int t = 0; t < 40; t++) begin
            if (!f_req && ($urandom_range(0, 1) == 1)) begin
                f_req = 1'b1; f_addr = $urandom;
            end
            if (!d_req && (($urandom_range(0, 1) == 1) || !f_req)) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
                d_size = 2'($urandom_range(0, 2));
            end
            a = $urandom_range(0, 5);
            run_txn(a, $urandom, -1, 1'($urandom_range(0, 1)));
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        test_drop_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
